// File: rtl/mem_port_if.sv
// mem_port_if: requester, grant and memory-side signals of the shared memory port
interface mem_port_if #(parameter int WIDTH = 16);
  logic             req0, req1, we0, we1;
  logic [WIDTH-1:0] addr0, addr1, wd0, wd1;
  logic             gnt0, gnt1, done0, done1, sel, mem_we;
  logic [WIDTH-1:0] rd, mem_addr, mem_wd, mem_rd;
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wd0, wd1, mem_rd,
    input  gnt0, gnt1, done0, done1, sel, mem_we, rd, mem_addr, mem_wd
  );
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wd0, wd1, mem_rd,
    output gnt0, gnt1, done0, done1, sel, mem_we, rd, mem_addr, mem_wd
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter/sequencer sharing one memory port between fetch and data access
module mem_port_arbiter #(
  parameter int WIDTH   = 16,
  parameter int MEM_LAT = 2
) (
  input logic       clk,
  input logic       rst_n,
  mem_port_if.slave bus
);
  localparam int CW = $clog2(MEM_LAT + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t           state;
  logic [CW-1:0]    cnt;
  logic             last, we_q, pick;
  logic [WIDTH-1:0] addr_in, wd_in;
  // pick=1 grants requester 1: it asks alone, or both ask and 0 went last
  assign pick    = bus.req1 & (~bus.req0 | ~last);
  assign addr_in = pick ? bus.addr1 : bus.addr0;
  assign wd_in   = pick ? bus.wd1 : bus.wd0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      last         <= 1'b1;
      we_q         <= 1'b0;
      bus.gnt0     <= 1'b0;
      bus.gnt1     <= 1'b0;
      bus.done0    <= 1'b0;
      bus.done1    <= 1'b0;
      bus.sel      <= 1'b0;
      bus.mem_we   <= 1'b0;
      bus.rd       <= '0;
      bus.mem_addr <= '0;
      bus.mem_wd   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req0 | bus.req1) begin
          bus.gnt0     <= ~pick;
          bus.gnt1     <= pick;
          bus.sel      <= pick;
          last         <= pick;
          bus.mem_addr <= addr_in;
          bus.mem_wd   <= wd_in;
          bus.mem_we   <= pick ? bus.we1 : bus.we0;
          we_q         <= pick ? bus.we1 : bus.we0;
          cnt          <= CW'(MEM_LAT - 1);
          state        <= BUSY;
        end
        BUSY: begin
          bus.mem_we <= 1'b0;
          if (cnt == '0) begin
            if (!we_q) bus.rd <= bus.mem_rd;
            bus.gnt0  <= 1'b0;
            bus.gnt1  <= 1'b0;
            bus.done0 <= ~bus.sel;
            bus.done1 <= bus.sel;
            state     <= DONE;
          end else cnt <= cnt - 1'b1;
        end
        DONE: begin
          bus.done0 <= 1'b0;
          bus.done1 <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of the memory port arbiter at MEM_LAT=2 and MEM_LAT=1
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  mem_port_if #(.WIDTH(16)) bus ();
  mem_port_if #(.WIDTH(16)) bus1 ();
  mem_port_arbiter #(.WIDTH(16), .MEM_LAT(2)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  mem_port_arbiter #(.WIDTH(16), .MEM_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int n0, n1, ovl, prev, g;
    {bus.req0, bus.req1, bus.we0, bus.we1} = '0;
    {bus.addr0, bus.addr1, bus.wd0, bus.wd1, bus.mem_rd} = '0;
    {bus1.req0, bus1.req1, bus1.we0, bus1.we1} = '0;
    {bus1.addr0, bus1.addr1, bus1.wd0, bus1.wd1, bus1.mem_rd} = '0;
    #1;
    check("rst_outs", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.sel, bus.mem_we}, 0);
    check("rst_data", {bus.rd, bus.mem_addr}, 0);
    tick(); tick();
    rst_n = 1'b1;
    // single read
    bus.req0 = 1; bus.addr0 = 16'h0010; bus.mem_rd = 16'hBEEF;
    tick();
    check("rd_gnt", {bus.gnt0, bus.gnt1, bus.sel, bus.mem_we}, 4'b1000);
    check("rd_addr", bus.mem_addr, 16'h0010);
    tick();
    check("rd_gnt2", {bus.gnt0, bus.done0}, 2'b10);
    tick();
    check("rd_done", {bus.gnt0, bus.done0, bus.done1}, 3'b010);
    check("rd_data", bus.rd, 16'hBEEF);
    bus.req0 = 0;
    tick();
    check("rd_done_end", {bus.done0, bus.gnt0}, 0);
    // single write, with stability of latched address/data
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 16'h0020; bus.wd1 = 16'hFFF6;
    tick();
    check("wr_gnt", {bus.gnt0, bus.gnt1, bus.sel, bus.mem_we}, 4'b0111);
    check("wr_bus", {bus.mem_addr, bus.mem_wd}, {16'h0020, 16'hFFF6});
    bus.addr1 = 16'h1111; bus.wd1 = 16'h2222; bus.addr0 = 16'h3333;
    tick();
    check("wr_we_off", {bus.gnt1, bus.sel, bus.mem_we}, 3'b110);
    check("wr_stable", {bus.mem_addr, bus.mem_wd}, {16'h0020, 16'hFFF6});
    bus.addr1 = 16'h4444; bus.wd1 = 16'h5555;
    tick();
    check("wr_done", {bus.gnt1, bus.done0, bus.done1}, 3'b001);
    check("wr_rd_keep", bus.rd, 16'hBEEF);
    check("wr_stable2", {bus.mem_addr, bus.mem_wd}, {16'h0020, 16'hFFF6});
    bus.req1 = 0; bus.we1 = 0;
    tick();
    check("wr_done_end", bus.done1, 0);
    // early drop of REQ0 on the second BUSY cycle
    bus.req0 = 1; bus.addr0 = 16'h0030; bus.mem_rd = 16'h1234;
    tick();
    check("ed_gnt", {bus.gnt0, bus.mem_addr}, {1'b1, 16'h0030});
    bus.req0 = 0;
    tick();
    check("ed_busy", {bus.gnt0, bus.done0}, 2'b10);
    tick();
    check("ed_done", {bus.gnt0, bus.done0}, 2'b01);
    check("ed_rd", bus.rd, 16'h1234);
    tick();
    check("ed_once", bus.done0, 0);
    tick();
    check("ed_no_regnt", {bus.gnt0, bus.done0}, 0);
    // reset in the middle of a write access
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 16'h0040; bus.wd0 = 16'h5555;
    tick();
    check("ar_gnt", {bus.gnt0, bus.mem_we}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("ar_outs", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.sel, bus.mem_we}, 0);
    check("ar_data", {bus.rd, bus.mem_addr, bus.mem_wd}, 0);
    tick();
    check("ar_no_done", {bus.done0, bus.gnt0}, 0);
    // contention after reset: tie goes to 0 first, then alternates
    bus.we0 = 0; bus.req1 = 1; bus.mem_rd = 16'h0BAD;
    rst_n = 1'b1;
    n0 = 0; n1 = 0; ovl = 0; prev = 0;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (bus.gnt0 && bus.gnt1) ovl++;
      if ((bus.gnt0 || bus.gnt1) && !prev) begin
        g = n0 + n1;
        check("rr_order", {31'd0, bus.gnt1}, (g % 2 == 1) ? 1 : 0);
        if (bus.gnt0) n0++;
        else n1++;
      end
      prev = bus.gnt0 || bus.gnt1;
    end
    check("rr_n0", n0, 10);
    check("rr_n1", n1, 10);
    check("rr_overlap", ovl, 0);
    bus.req0 = 0; bus.req1 = 0;
    // MEM_LAT=1: single BUSY cycle
    bus1.req0 = 1; bus1.addr0 = 16'h0050; bus1.mem_rd = 16'hA5A5;
    tick();
    check("l1_rd_gnt", {bus1.gnt0, bus1.mem_we, bus1.done0}, 3'b100);
    tick();
    check("l1_rd_done", {bus1.gnt0, bus1.done0}, 2'b01);
    check("l1_rd", bus1.rd, 16'hA5A5);
    bus1.req0 = 0;
    tick();
    bus1.req0 = 1; bus1.we0 = 1; bus1.wd0 = 16'h0077; bus1.mem_rd = 16'hFFFF;
    tick();
    check("l1_wr_gnt", {bus1.gnt0, bus1.mem_we, bus1.mem_wd}, {2'b11, 16'h0077});
    tick();
    check("l1_wr_done", {bus1.gnt0, bus1.mem_we, bus1.done0}, 3'b001);
    check("l1_wr_rd", bus1.rd, 16'hA5A5);
    bus1.req0 = 0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter and sequencer for the single 16-bit memory port of the 16-bit processor. It shares the port between instruction fetch (requester 0) and data access (requester 1). It drives the address/write-data mux select for the port, latches the winning request, holds it stable for a fixed memory latency, and returns read data with a one-cycle done pulse. Arbitration is round-robin, so neither requester starves.

## Interface
- WIDTH, 16, data and address width
- MEM_LAT, 2, cycles the memory needs per access (≥1)
- CLK  in  1  clock, all state changes on rising edge
- RST_N  in  1  asynchronous, active-low reset
- REQ0, REQ1  in  1  access request from fetch / data unit
- ADDR0, ADDR1  in  WIDTH  request address
- WE0, WE1  in  1  1 = write, 0 = read
- WD0, WD1  in  WIDTH  write data
- GNT0, GNT1  out  1  requester owns the port (one-hot or both 0)
- DONE0, DONE1  out  1  one-cycle completion pulse
- RD  out  WIDTH  read data of last completed read
- SEL  out  1  port mux select: 0 = requester 0, 1 = requester 1
- MEM_ADDR  out  WIDTH  latched address to memory
- MEM_WD  out  WIDTH  latched write data to memory
- MEM_WE  out  1  memory write strobe
- MEM_RD  in  WIDTH  memory read data, valid on the last BUSY cycle

## Operation
- States: IDLE, BUSY, DONE. A down-counter CNT of width ceil(log2(MEM_LAT+1)) counts BUSY cycles.
- IDLE: if exactly one REQx is high, grant it. If both are high, grant the requester not granted last (pointer LAST). After reset, LAST = 1, so requester 0 wins the first tie. If neither is high, stay in IDLE.
- On grant, on the same edge: GNTx=1, SEL=x, LAST=x, and latch MEM_ADDR/MEM_WD/WE from requester x. CNT=MEM_LAT-1. Go to BUSY.
- BUSY: MEM_ADDR, MEM_WD and SEL hold stable. MEM_WE is high only on the first BUSY cycle, and only for writes. When CNT=0, capture RD<=MEM_RD if the access is a read, drop GNTx, and go to DONE. Otherwise decrement CNT.
- DONE: DONEx=1 for exactly one cycle, then go to IDLE unconditionally. No arbitration occurs in DONE.
- REQx dropped during BUSY is ignored; the access completes and DONEx still pulses. Requesters deassert REQx in the cycle they see DONEx. A REQx still high in the following IDLE cycle is a new request.
- Writes leave RD unchanged. RD holds its value until the next read completes.
- Inputs of the non-granted requester have no effect on MEM_* while BUSY.

## Timing
- Reset (async, RST_N=0): state=IDLE, CNT=0, LAST=1. GNT0=GNT1=DONE0=DONE1=SEL=MEM_WE=0, RD=MEM_ADDR=MEM_WD=0. Outputs clear immediately, without waiting for a clock edge.
- Reset during BUSY or DONE aborts the access: no DONE pulse, no RD update.
- Latency: REQx sampled high in IDLE at edge k gives GNTx high from edge k to edge k+MEM_LAT and DONEx high from edge k+MEM_LAT to edge k+MEM_LAT+1. RD is valid while DONEx is high.
- Minimum spacing between grants is MEM_LAT+2 cycles (BUSY×MEM_LAT, DONE, IDLE).
- With both REQs held continuously, grants alternate 0,1,0,1… every MEM_LAT+2 cycles.
- MEM_LAT=1: a single BUSY cycle, in which MEM_WE and the RD capture coincide.
- All outputs are registered; there is no combinational path from REQ to GNT.

## Test plan
- Reset: drive RST_N=0 mid-BUSY with REQ0=1 and WE0=1 → all outputs go to 0 before the next edge, no DONE0 pulse, and after release the first tie is granted to requester 0.
- Single read: MEM_LAT=2, REQ0=1, ADDR0=16'h0010, MEM_RD=16'hBEEF → GNT0 for 2 cycles with MEM_ADDR=16'h0010 and SEL=0, then DONE0 for 1 cycle with RD=16'hBEEF.
- Single write: REQ1=1, WE1=1, ADDR1=16'h0020, WD1=16'hFFF6 (−10) → SEL=1, MEM_WE high for exactly the first BUSY cycle, MEM_WD=16'hFFF6, DONE1 pulses, and RD is unchanged.
- Contention: REQ0=REQ1=1 held for 20 accesses → GNT alternates starting with 0, each requester gets 10 grants, and GNT0 and GNT1 are never high together.
- Stability: change ADDR0/ADDR1/WD1 every cycle during BUSY → MEM_ADDR and MEM_WD stay equal to the values latched at the grant edge.
- Early drop: REQ0 deasserted on the second BUSY cycle → the access completes and DONE0 still pulses once.
